// File: rtl/config_sched_if.sv
// Command/handshake bundle between the CGRA controller and the configuration sequencer.
// The master drives commands; the slave (config_sched) drives memory control and status.
interface config_sched_if #(
    parameter int AW = 3,
    parameter int CW = 16
);
    logic          cfg_start;
    logic [AW:0]   cfg_len;
    logic          cfg_valid;
    logic          cfg_ready;
    logic          cm_wr_en;
    logic [AW-1:0] cm_wr_addr;
    logic          run_start;
    logic [CW-1:0] run_iter;
    logic          stall;
    logic          abort;
    logic          cm_rd_en;
    logic [AW-1:0] cm_rd_addr;
    logic          busy;
    logic          loaded;
    logic          done;
    logic [CW-1:0] iter_cnt;
    logic          err;

    modport master (
        output cfg_start, cfg_len, cfg_valid, run_start, run_iter, stall, abort,
        input  cfg_ready, cm_wr_en, cm_wr_addr, cm_rd_en, cm_rd_addr,
               busy, loaded, done, iter_cnt, err
    );

    modport slave (
        input  cfg_start, cfg_len, cfg_valid, run_start, run_iter, stall, abort,
        output cfg_ready, cm_wr_en, cm_wr_addr, cm_rd_en, cm_rd_addr,
               busy, loaded, done, iter_cnt, err
    );
endinterface

// File: rtl/config_sched.sv
// Configuration-memory sequencer: writes instruction bundles into context slots, then
// replays the loaded contexts for a programmed number of iterations.
module config_sched #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int CW    = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    config_sched_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

    state_t        r_state;
    state_t        w_next;
    logic [AW:0]   r_ctx_len;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_iter_cnt;
    logic [CW-1:0] r_run_iter;
    logic          r_loaded;
    logic          r_err;

    logic          w_len_ok;
    logic          w_wr_last;
    logic          w_rd_last;
    logic [CW-1:0] w_iter_next;
    logic          w_load_go;
    logic          w_run_go;
    logic          w_err_set;
    logic          w_wr_hs;
    logic          w_rd_step;
    logic          w_load_abort;
    logic          w_cfg_ready;

    assign w_len_ok    = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_MAX);
    assign w_wr_last   = (({1'b0, r_wr_ptr} + (AW+1)'(1)) == r_ctx_len);
    assign w_rd_last   = (({1'b0, r_rd_ptr} + (AW+1)'(1)) == r_ctx_len);
    assign w_iter_next = r_iter_cnt + CW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_load_go    = 1'b0;
        w_run_go     = 1'b0;
        w_err_set    = 1'b0;
        w_wr_hs      = 1'b0;
        w_rd_step    = 1'b0;
        w_load_abort = 1'b0;
        unique case (r_state)
            IDLE: begin
                // cfg_start outranks run_start; a simultaneous run_start is silently dropped
                if (bus.cfg_start) begin
                    if (w_len_ok) begin
                        w_load_go = 1'b1;
                        w_next    = LOAD;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end else if (bus.run_start) begin
                    if (r_loaded) begin
                        w_run_go = 1'b1;
                        w_next   = (bus.run_iter == '0) ? DONE : RUN;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
            end
            LOAD: begin
                w_err_set = bus.cfg_start | bus.run_start;
                if (bus.abort) begin
                    w_load_abort = 1'b1;
                    w_next       = IDLE;
                end else if (bus.cfg_valid) begin
                    w_wr_hs = 1'b1;
                    if (w_wr_last) begin
                        w_next = IDLE;
                    end
                end
            end
            RUN: begin
                w_err_set = bus.cfg_start | bus.run_start;
                if (bus.abort) begin
                    w_next = IDLE;
                end else if (!bus.stall) begin
                    w_rd_step = 1'b1;
                    if (w_rd_last && (w_iter_next == r_run_iter)) begin
                        w_next = DONE;
                    end
                end
            end
            DONE: begin
                w_err_set = bus.cfg_start | bus.run_start;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ctx_len  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_iter_cnt <= '0;
            r_run_iter <= '0;
            r_loaded   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (w_load_go) begin
                r_ctx_len <= bus.cfg_len;
                r_wr_ptr  <= '0;
                r_loaded  <= 1'b0;
            end
            if (w_load_abort) begin
                r_loaded <= 1'b0;
            end
            if (w_wr_hs) begin
                if (w_wr_last) begin
                    r_wr_ptr <= '0;
                    r_loaded <= 1'b1;
                end else begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
            end
            if (w_run_go) begin
                r_run_iter <= bus.run_iter;
                r_rd_ptr   <= '0;
                r_iter_cnt <= '0;
            end
            if (w_rd_step) begin
                if (w_rd_last) begin
                    r_rd_ptr   <= '0;
                    r_iter_cnt <= w_iter_next;
                end else begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
            end
        end
    end

    assign w_cfg_ready    = (r_state == LOAD);
    assign bus.cfg_ready  = w_cfg_ready;
    assign bus.cm_wr_en   = bus.cfg_valid & w_cfg_ready;
    assign bus.cm_wr_addr = r_wr_ptr;
    assign bus.cm_rd_en   = (r_state == RUN);
    assign bus.cm_rd_addr = r_rd_ptr;
    assign bus.busy       = (r_state == LOAD) || (r_state == RUN);
    assign bus.loaded     = r_loaded;
    assign bus.done       = (r_state == DONE);
    assign bus.iter_cnt   = r_iter_cnt;
    assign bus.err        = r_err;
endmodule

// File: tb/tb_config_sched.sv
// Directed bench for config_sched; write/read addresses are scoreboarded against
// queues filled as stimulus is driven and drained by a negedge monitor.
module tb_config_sched;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int CW    = 16;

    logic clk = 1'b0;
    logic rst_n;

    config_sched_if #(.AW(AW), .CW(CW)) bus ();

    config_sched #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;
    int exp_done = 0;
    logic [AW-1:0] wr_q[$];
    logic [AW-1:0] rd_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".cfg_ready"},  32'(bus.cfg_ready),  0);
        chk({tag, ".cm_wr_en"},   32'(bus.cm_wr_en),   0);
        chk({tag, ".cm_wr_addr"}, 32'(bus.cm_wr_addr), 0);
        chk({tag, ".cm_rd_en"},   32'(bus.cm_rd_en),   0);
        chk({tag, ".cm_rd_addr"}, 32'(bus.cm_rd_addr), 0);
        chk({tag, ".busy"},       32'(bus.busy),       0);
        chk({tag, ".loaded"},     32'(bus.loaded),     0);
        chk({tag, ".done"},       32'(bus.done),       0);
        chk({tag, ".iter_cnt"},   32'(bus.iter_cnt),   0);
        chk({tag, ".err"},        32'(bus.err),        0);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.cm_wr_en) begin
                chk("wr_expected", 32'(wr_q.size() != 0), 1);
                if (wr_q.size() != 0) chk("wr_addr", 32'(bus.cm_wr_addr), 32'(wr_q.pop_front()));
            end
            if (bus.cm_rd_en) begin
                chk("rd_expected", 32'(rd_q.size() != 0), 1);
                if (rd_q.size() != 0) chk("rd_addr", 32'(bus.cm_rd_addr), 32'(rd_q.pop_front()));
            end
            if (bus.done) n_done++;
        end else if (rd_q.size() != 0 && bus.cm_rd_en) begin
            // reset asserted mid-cycle: the run is still visible until the edge
            chk("rd_addr_rst", 32'(bus.cm_rd_addr), 32'(rd_q.pop_front()));
        end
    end

    initial begin
        rst_n         = 1'b0;
        bus.cfg_start = 1'b0;
        bus.cfg_len   = '0;
        bus.cfg_valid = 1'b0;
        bus.run_start = 1'b0;
        bus.run_iter  = '0;
        bus.stall     = 1'b0;
        bus.abort     = 1'b0;
        step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();

        // plain load of 8 contexts
        bus.cfg_start = 1'b1;
        bus.cfg_len   = 4'd8;
        step();
        bus.cfg_start = 1'b0;
        bus.cfg_valid = 1'b1;
        for (int i = 0; i < 8; i++) wr_q.push_back(AW'(i));
        chk("load8.cfg_ready", 32'(bus.cfg_ready), 1);
        chk("load8.busy", 32'(bus.busy), 1);
        for (int i = 0; i < 7; i++) step();
        chk("load8.loaded_early", 32'(bus.loaded), 0);
        step();
        chk("load8.loaded", 32'(bus.loaded), 1);
        chk("load8.err", 32'(bus.err), 0);
        chk("load8.cfg_ready_off", 32'(bus.cfg_ready), 0);
        chk("idle.valid_ignored", 32'(bus.cm_wr_en), 0);
        step();
        bus.cfg_valid = 1'b0;

        // gapped load of 3 contexts
        bus.cfg_start = 1'b1;
        bus.cfg_len   = 4'd3;
        step();
        bus.cfg_start = 1'b0;
        chk("gap.loaded_cleared", 32'(bus.loaded), 0);
        for (int i = 0; i < 3; i++) wr_q.push_back(AW'(i));
        for (int i = 0; i < 5; i++) begin
            bus.cfg_valid = ((i % 2) == 0);
            if (i == 4) chk("gap.cfg_ready_before_last", 32'(bus.cfg_ready), 1);
            step();
        end
        bus.cfg_valid = 1'b0;
        chk("gap.cfg_ready_after", 32'(bus.cfg_ready), 0);
        chk("gap.loaded", 32'(bus.loaded), 1);

        // run L=3, I=2, two stall cycles
        bus.run_start = 1'b1;
        bus.run_iter  = 16'd2;
        rd_q.push_back(3'd0); rd_q.push_back(3'd1); rd_q.push_back(3'd1);
        rd_q.push_back(3'd1); rd_q.push_back(3'd2); rd_q.push_back(3'd0);
        rd_q.push_back(3'd1); rd_q.push_back(3'd2);
        exp_done++;
        step();
        bus.run_start = 1'b0;
        chk("run.first_addr", 32'(bus.cm_rd_addr), 0);
        for (int c = 0; c < 8; c++) begin
            bus.stall = (c == 1 || c == 2);
            if (c == 7) chk("run.done_not_early", 32'(bus.done), 0);
            step();
        end
        bus.stall = 1'b0;
        chk("run.done", 32'(bus.done), 1);
        chk("run.rd_en_off", 32'(bus.cm_rd_en), 0);
        chk("run.iter_cnt", 32'(bus.iter_cnt), 2);
        step();
        chk("run.done_pulse", 32'(bus.done), 0);
        chk("run.busy_idle", 32'(bus.busy), 0);
        chk("run.loaded_kept", 32'(bus.loaded), 1);

        // zero iterations
        bus.run_start = 1'b1;
        bus.run_iter  = 16'd0;
        exp_done++;
        step();
        bus.run_start = 1'b0;
        chk("zero.done", 32'(bus.done), 1);
        chk("zero.rd_en", 32'(bus.cm_rd_en), 0);
        chk("zero.iter_cnt", 32'(bus.iter_cnt), 0);
        step();

        // abort in the 4th RUN cycle, then re-run
        bus.run_start = 1'b1;
        bus.run_iter  = 16'd5;
        rd_q.push_back(3'd0); rd_q.push_back(3'd1); rd_q.push_back(3'd2); rd_q.push_back(3'd0);
        step();
        bus.run_start = 1'b0;
        step(); step(); step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort.busy", 32'(bus.busy), 0);
        chk("abort.done", 32'(bus.done), 0);
        chk("abort.loaded", 32'(bus.loaded), 1);
        chk("abort.rd_en", 32'(bus.cm_rd_en), 0);
        bus.run_start = 1'b1;
        bus.run_iter  = 16'd1;
        rd_q.push_back(3'd0); rd_q.push_back(3'd1); rd_q.push_back(3'd2);
        exp_done++;
        step();
        bus.run_start = 1'b0;
        chk("rerun.first_addr", 32'(bus.cm_rd_addr), 0);
        step(); step(); step();
        chk("rerun.done", 32'(bus.done), 1);
        chk("rerun.iter_cnt", 32'(bus.iter_cnt), 1);
        step();
        chk("rerun.err", 32'(bus.err), 0);

        // cfg_start and run_start together: load wins, no error
        bus.cfg_start = 1'b1;
        bus.run_start = 1'b1;
        bus.cfg_len   = 4'd1;
        step();
        bus.cfg_start = 1'b0;
        bus.run_start = 1'b0;
        chk("both.in_load", 32'(bus.cfg_ready), 1);
        chk("both.rd_en", 32'(bus.cm_rd_en), 0);
        chk("both.err", 32'(bus.err), 0);
        bus.cfg_valid = 1'b1;
        wr_q.push_back(3'd0);
        step();
        bus.cfg_valid = 1'b0;
        chk("both.loaded", 32'(bus.loaded), 1);

        // cfg_len = 0
        bus.cfg_start = 1'b1;
        bus.cfg_len   = 4'd0;
        step();
        bus.cfg_start = 1'b0;
        chk("len0.err", 32'(bus.err), 1);
        chk("len0.busy", 32'(bus.busy), 0);
        chk("len0.loaded_kept", 32'(bus.loaded), 1);

        // run before any load
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.run_start = 1'b1;
        bus.run_iter  = 16'd1;
        step();
        bus.run_start = 1'b0;
        chk("noload.err", 32'(bus.err), 1);
        chk("noload.rd_en", 32'(bus.cm_rd_en), 0);
        chk("noload.busy", 32'(bus.busy), 0);

        // cfg_len = 9
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.cfg_start = 1'b1;
        bus.cfg_len   = 4'd9;
        step();
        bus.cfg_start = 1'b0;
        chk("len9.err", 32'(bus.err), 1);
        chk("len9.busy", 32'(bus.busy), 0);
        chk("len9.cfg_ready", 32'(bus.cfg_ready), 0);

        // reset during RUN
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.cfg_start = 1'b1;
        bus.cfg_len   = 4'd2;
        step();
        bus.cfg_start = 1'b0;
        bus.cfg_valid = 1'b1;
        wr_q.push_back(3'd0); wr_q.push_back(3'd1);
        step(); step();
        bus.cfg_valid = 1'b0;
        bus.run_start = 1'b1;
        bus.run_iter  = 16'd3;
        rd_q.push_back(3'd0); rd_q.push_back(3'd1); rd_q.push_back(3'd0);
        step();
        bus.run_start = 1'b0;
        step(); step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_all_zero("rstrun");
        bus.run_start = 1'b1;
        step();
        bus.run_start = 1'b0;
        chk("rstrun.err", 32'(bus.err), 1);
        chk("rstrun.rd_en", 32'(bus.cm_rd_en), 0);
        step();

        chk("wr_q_drained", 32'(wr_q.size()), 0);
        chk("rd_q_drained", 32'(rd_q.size()), 0);
        chk("done_pulses", 32'(n_done), 32'(exp_done));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/config_sched.md
# config_sched

Sequencer for the CGRA configuration memory. It drives the memory's write port while instruction bundles are loaded, then steps the read address through the loaded contexts for a programmed number of iterations. Instruction data flows straight into the configuration memory. This block produces only the enables, addresses, handshakes and status.

## Interface
- `DEPTH`, 8: number of context slots in the configuration memory.
- `AW`, 3: address width; must satisfy 2^AW >= DEPTH.
- `CW`, 16: iteration counter width.

- `clk`  in  1  clock; everything is sampled on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cfg_start`  in  1  pulse: begin a load of `cfg_len` contexts.
- `cfg_len`  in  AW+1  number of contexts to load; legal range 1..DEPTH.
- `cfg_valid`  in  1  an instruction bundle is present on the memory write data.
- `cfg_ready`  out  1  block accepts bundles.
- `cm_wr_en`  out  1  memory write enable.
- `cm_wr_addr`  out  AW  memory write address.
- `run_start`  in  1  pulse: execute the loaded contexts.
- `run_iter`  in  CW  iteration count, latched at `run_start`.
- `stall`  in  1  datapath stall; the current context is held.
- `abort`  in  1  cancel the current load or run.
- `cm_rd_en`  out  1  memory read enable.
- `cm_rd_addr`  out  AW  memory read address (context index).
- `busy`  out  1  state is LOAD or RUN.
- `loaded`  out  1  a complete context set is present.
- `done`  out  1  one-cycle pulse at the end of a run.
- `iter_cnt`  out  CW  number of completed iterations.
- `err`  out  1  sticky flag for an illegal command; cleared only by reset.

## Operation
**States:** IDLE, LOAD, RUN, DONE.

**IDLE**
- `cfg_start` with `cfg_len` in 1..DEPTH: latch `ctx_len`, set `wr_ptr`=0, clear `loaded`, go to LOAD.
- `cfg_len`=0 or `cfg_len` > DEPTH: set `err`, stay in IDLE, leave `loaded` unchanged.
- `run_start` with `loaded`=1: latch `run_iter`, set `rd_ptr`=0 and `iter_cnt`=0. Go to RUN, or go directly to DONE if `run_iter`=0.
- `run_start` with `loaded`=0: set `err`, stay in IDLE.
- `cfg_start` and `run_start` in the same cycle: `cfg_start` wins and `run_start` is dropped without setting `err`.

**LOAD**
- `cfg_ready`=1.
- `cm_wr_en` = `cfg_valid` & `cfg_ready`, combinational, so the memory captures the bundle on the same edge as the handshake.
- `cm_wr_addr` = `wr_ptr`.
- Each handshake increments `wr_ptr`.
- The handshake with `wr_ptr` = `ctx_len`-1 sets `loaded`=1 and returns to IDLE.

**RUN**
- `cm_rd_en`=1 and `cm_rd_addr`=`rd_ptr`.
- With `stall`=0, `rd_ptr` advances each cycle. After `ctx_len`-1 it wraps to 0 and `iter_cnt` increments.
- The wrap that brings `iter_cnt` to the latched `run_iter` goes to DONE.
- With `stall`=1, `rd_ptr`, `iter_cnt` and the state all hold, and `cm_rd_en` stays 1.

**DONE**
- `done`=1 for one cycle, then IDLE.
- `loaded` stays 1, so the contexts can be re-run without reloading.
- `iter_cnt` holds its value until the next `run_start`.

**Other rules**
- `abort` in LOAD or RUN returns to IDLE on the next edge. There is no `done` pulse. `loaded` is cleared if aborted in LOAD and kept if aborted in RUN. `abort` has priority over `stall` and `cfg_valid`.
- `cfg_start` or `run_start` arriving in LOAD, RUN or DONE is ignored and sets `err`.
- `cfg_valid` is ignored outside LOAD.

## Timing
- **Reset** (`rst_n`=0 sampled at an edge): state IDLE. `cfg_ready`, `cm_wr_en`, `cm_wr_addr`, `cm_rd_en`, `cm_rd_addr`, `busy`, `loaded`, `done`, `iter_cnt` and `err` are all 0. Reset mid-LOAD or mid-RUN behaves identically, and the memory contents are considered invalid afterwards.
- **Output types:** all outputs except `cm_wr_en` are registered or state-decoded. `cm_wr_en` is the only combinational output.
- **Load:** `cfg_start` sampled at edge N puts the block in LOAD from cycle N+1. With `cfg_valid` held at 1, `ctx_len` writes take cycles N+1..N+L, and `loaded`=1 from cycle N+L+1.
- **Run:** `run_start` sampled at edge N puts `cm_rd_addr`=0 in cycle N+1. With no stall, RUN lasts L·I cycles, `done` is asserted in cycle N+L·I+1, and IDLE follows in the next cycle.
- **Zero iterations:** `run_iter`=0 puts `done` in cycle N+1 and `cm_rd_en` never asserts.
- **Stall:** each stall cycle extends RUN by exactly one cycle.

## Test plan
- **Plain load:** reset, then `cfg_start` with `cfg_len`=8 and `cfg_valid`=1 for 8 cycles -> `cm_wr_addr` 0..7 on consecutive cycles, `loaded`=1, `err`=0.
- **Gapped load:** `cfg_len`=3 with `cfg_valid` pattern 1,0,1,0,1 -> exactly 3 writes to addresses 0, 1, 2; `cfg_ready` drops after the third write.
- **Run with stall:** `run_start` with L=3 and `run_iter`=2, `stall` high for 2 cycles mid-run -> `cm_rd_addr` sequence 0,1,1,1,2,0,1,2, then `done` one cycle later, `iter_cnt`=2.
- **Illegal commands:** `run_start` before any load -> `err`=1, no `cm_rd_en`. Also `cfg_len`=0 -> `err`=1, state stays IDLE. Also `cfg_len`=9 -> `err`=1, state stays IDLE.
- **Abort:** `abort` during the 4th cycle of RUN -> IDLE on the next cycle, no `done`, `loaded`=1. A re-run then restarts at `cm_rd_addr`=0.
- **Reset mid-run:** `rst_n` low for one edge during RUN -> all outputs 0 on the next cycle. `run_start` then sets `err` because `loaded`=0.
